mem_access_ctrl: RTL

- MEM-stage responder that consumes the EX/MEM pipeline register's memread/memwrite, address (ALU result) and store data, and executes the access on the ThinPad shared RAM1/UART bus.
- Sequences SRAM and UART strobes and returns load data.
- Asserts mem_stall to freeze upstream pipeline registers while a multi-cycle access is in flight.

---
 rtl/mem_access_ctrl_if.sv | 35 +++
 rtl/mem_access_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response and ThinPad bus strobe bundle for mem_access_ctrl.
// The shared 16-bit data bus stays a plain inout port on the controller.
interface mem_access_ctrl_if;
  logic        memread_in;
  logic        memwrite_in;
  logic [15:0] addr_in;
  logic [15:0] wdata_in;
  logic [15:0] rdata_out;
  logic        mem_stall;
  logic [17:0] ram_addr;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic        ram_en_n;
  logic        uart_rdn;
  logic        uart_wrn;
  logic        uart_data_ready;
  logic        uart_tbre;
  logic        uart_tsre;

  // Pipeline / board side: issues requests, owns the UART status pins.
  modport master (
    output memread_in, memwrite_in, addr_in, wdata_in,
           uart_data_ready, uart_tbre, uart_tsre,
    input  rdata_out, mem_stall, ram_addr,
           ram_oe_n, ram_we_n, ram_en_n, uart_rdn, uart_wrn
  );

  // Controller side.
  modport slave (
    input  memread_in, memwrite_in, addr_in, wdata_in,
           uart_data_ready, uart_tbre, uart_tsre,
    output rdata_out, mem_stall, ram_addr,
           ram_oe_n, ram_we_n, ram_en_n, uart_rdn, uart_wrn
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller for the ThinPad shared RAM1/UART bus.
// Strobes and bus-drive enable are registered from the next state so every
// strobe comes straight off a flop: async reset forces them high with no glitch.
module mem_access_ctrl #(
  parameter int unsigned  RAM_WAIT       = 1,
  parameter logic [15:0]  UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0]  UART_STAT_ADDR = 16'hBF01
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.slave  bus,
  inout  wire  [15:0]       ram_data
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RAM_RD,
    S_RAM_WR_SETUP,
    S_RAM_WR,
    S_UART_RD,
    S_UART_RD_CAP,
    S_UART_WR_WAIT,
    S_UART_WR,
    S_UART_WR_HOLD,
    S_DONE
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(RAM_WAIT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_wait;
  logic [3:0]  w_wait_next;
  logic [15:0] r_addr;
  logic [15:0] w_addr_next;
  logic [15:0] r_bus_data;
  logic [15:0] w_bus_data_next;
  logic [15:0] r_rdata;
  logic [15:0] w_rdata_next;

  logic        r_ram_oe_n, w_ram_oe_n_next;
  logic        r_ram_we_n, w_ram_we_n_next;
  logic        r_ram_en_n, w_ram_en_n_next;
  logic        r_uart_rdn, w_uart_rdn_next;
  logic        r_uart_wrn, w_uart_wrn_next;
  logic        r_drive,    w_drive_next;

  logic        w_req;
  logic        w_uart_ready;

  assign w_req        = bus.memread_in | bus.memwrite_in;
  assign w_uart_ready = bus.uart_tbre & bus.uart_tsre;

  // State, latched request and registered strobes; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wait     <= 4'd0;
      r_addr     <= 16'd0;
      r_bus_data <= 16'd0;
      r_rdata    <= 16'd0;
      r_ram_oe_n <= 1'b1;
      r_ram_we_n <= 1'b1;
      r_ram_en_n <= 1'b1;
      r_uart_rdn <= 1'b1;
      r_uart_wrn <= 1'b1;
      r_drive    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait     <= w_wait_next;
      r_addr     <= w_addr_next;
      r_bus_data <= w_bus_data_next;
      r_rdata    <= w_rdata_next;
      r_ram_oe_n <= w_ram_oe_n_next;
      r_ram_we_n <= w_ram_we_n_next;
      r_ram_en_n <= w_ram_en_n_next;
      r_uart_rdn <= w_uart_rdn_next;
      r_uart_wrn <= w_uart_wrn_next;
      r_drive    <= w_drive_next;
    end
  end

  // Next-state, data capture, and strobe decode of the state being entered.
  always_comb begin
    w_state_next    = r_state;
    w_wait_next     = r_wait;
    w_addr_next     = r_addr;
    w_bus_data_next = r_bus_data;
    w_rdata_next    = r_rdata;

    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_addr_next     = bus.addr_in;
          w_bus_data_next = bus.wdata_in;
          w_wait_next     = 4'd0;
          // A simultaneous read+write request is executed as a write.
          if (bus.memwrite_in) begin
            if (bus.addr_in == UART_DATA_ADDR) begin
              w_bus_data_next = {8'b0, bus.wdata_in[7:0]};
              w_state_next    = S_UART_WR_WAIT;
            end else if (bus.addr_in == UART_STAT_ADDR) begin
              w_state_next = S_DONE;
            end else begin
              w_state_next = S_RAM_WR_SETUP;
            end
          end else begin
            if (bus.addr_in == UART_DATA_ADDR) begin
              w_state_next = S_UART_RD;
            end else if (bus.addr_in == UART_STAT_ADDR) begin
              w_rdata_next = {14'b0, bus.uart_data_ready, w_uart_ready};
              w_state_next = S_DONE;
            end else begin
              w_state_next = S_RAM_RD;
            end
          end
        end
      end
      S_RAM_RD: begin
        if (r_wait == WAIT_LAST) begin
          w_rdata_next = ram_data;
          w_wait_next  = 4'd0;
          w_state_next = S_DONE;
        end else begin
          w_wait_next = 4'(r_wait + 4'd1);
        end
      end
      S_RAM_WR_SETUP: w_state_next = S_RAM_WR;
      S_RAM_WR: begin
        if (r_wait == WAIT_LAST) begin
          w_wait_next  = 4'd0;
          w_state_next = S_DONE;
        end else begin
          w_wait_next = 4'(r_wait + 4'd1);
        end
      end
      S_UART_RD:     w_state_next = S_UART_RD_CAP;
      S_UART_RD_CAP: begin
        w_rdata_next = {8'b0, ram_data[7:0]};
        w_state_next = S_DONE;
      end
      S_UART_WR_WAIT: begin
        if (w_uart_ready) begin
          w_state_next = S_UART_WR;
        end
      end
      S_UART_WR:      w_state_next = S_UART_WR_HOLD;
      S_UART_WR_HOLD: w_state_next = S_DONE;
      S_DONE:         w_state_next = S_IDLE;
      default:        w_state_next = S_IDLE;
    endcase

    w_ram_oe_n_next = 1'b1;
    w_ram_we_n_next = 1'b1;
    w_ram_en_n_next = 1'b1;
    w_uart_rdn_next = 1'b1;
    w_uart_wrn_next = 1'b1;
    w_drive_next    = 1'b0;

    // The bus is never driven in a state that enables a read strobe.
    case (w_state_next)
      S_RAM_RD: begin
        w_ram_en_n_next = 1'b0;
        w_ram_oe_n_next = 1'b0;
      end
      S_RAM_WR_SETUP: begin
        w_ram_en_n_next = 1'b0;
        w_drive_next    = 1'b1;
      end
      S_RAM_WR: begin
        w_ram_en_n_next = 1'b0;
        w_ram_we_n_next = 1'b0;
        w_drive_next    = 1'b1;
      end
      S_UART_RD, S_UART_RD_CAP: begin
        w_uart_rdn_next = 1'b0;
      end
      S_UART_WR_WAIT, S_UART_WR_HOLD: begin
        w_drive_next = 1'b1;
      end
      S_UART_WR: begin
        w_uart_wrn_next = 1'b0;
        w_drive_next    = 1'b1;
      end
      default: ;
    endcase
  end

  // Stall while a request is unfinished; released in DONE and held low in reset.
  assign bus.mem_stall = rst & ((r_state == S_IDLE) ? w_req : (r_state != S_DONE));

  assign bus.rdata_out = r_rdata;
  assign bus.ram_addr  = {2'b00, r_addr};
  assign bus.ram_oe_n  = r_ram_oe_n;
  assign bus.ram_we_n  = r_ram_we_n;
  assign bus.ram_en_n  = r_ram_en_n;
  assign bus.uart_rdn  = r_uart_rdn;
  assign bus.uart_wrn  = r_uart_wrn;
  assign ram_data      = r_drive ? r_bus_data : 16'hzzzz;

endmodule
